// File: rtl/sqrt_rr_scheduler_pkg.sv
// Shared types for the sqrt scheduler: tagged direction records, operand width defines, FSM states.
// WIDTH/Q_BITS may be overridden on the command line before this file is compiled.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef Q_BITS
`define Q_BITS 16
`endif

package sqrt_rr_scheduler_pkg;

  localparam int TD_TAG_W = 64;

  typedef struct packed {
    logic [TD_TAG_W-1:0] tag;
    logic [`WIDTH-1:0]   dir_x;
    logic [`WIDTH-1:0]   dir_y;
  } TaggedDirection;

  typedef struct packed {
    TaggedDirection    td;
    logic [`WIDTH-1:0] len;
  } TaggedDirection_len;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } sched_state_e;

endpackage

// File: rtl/sqrt_rr_scheduler_id_fifo.sv
// In-order FIFO of requester IDs, one entry per operation outstanding in the sqrt unit.
// Head is combinational so a returning result can be routed in the cycle it arrives.
module sched_id_fifo #(
  parameter int DEPTH = 32,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_push,
  input  logic [ID_W-1:0] i_push_id,
  input  logic            i_pop,
  output logic [ID_W-1:0] o_head_id,
  output logic            o_empty
);

  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [ID_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_full;
  logic            w_push;
  logic            w_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_push    = i_push && !w_full;
  assign w_pop     = i_pop && !o_empty;
  assign o_head_id = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sqrt_rr_scheduler.sv
// Round-robin share of one sqrt unit among NUM_REQ requesters; issue registered one cycle after handshake,
// results routed back combinationally. Define SQRT_SCHED_STATS_EN to add stat_issued/stat_stall counters.
module sqrt_rr_scheduler
  import sqrt_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = `WIDTH,
  parameter int TAG_SIZE     = 64,
  parameter int MAX_INFLIGHT = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_x,
  input  TaggedDirection [NUM_REQ-1:0]      req_td,
  output logic                              sq_start,
  output logic [WIDTH-1:0]                  sq_x,
  output TaggedDirection                    sq_td,
  input  logic                              sq_valid,
  input  TaggedDirection_len                sq_tdl,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output TaggedDirection_len                rsp_tdl,
  input  logic                              flush,
  output logic                              flush_done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight
`ifdef SQRT_SCHED_STATS_EN
  ,
  output logic [31:0]                       stat_issued,
  output logic [31:0]                       stat_stall
`endif
);

  localparam int               ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int               CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W:0]   MAX_C = (CNT_W + 1)'(MAX_INFLIGHT);

  if (TAG_SIZE != TD_TAG_W || WIDTH != `WIDTH) begin : g_param_mismatch
    $error("TAG_SIZE/WIDTH must match the shared TaggedDirection layout");
  end

  sched_state_e     r_state;
  sched_state_e     w_state_nxt;
  logic [ID_W-1:0]  r_last_grant;
  logic [ID_W-1:0]  w_win;
  logic [ID_W-1:0]  w_idx;
  logic             w_any_vld;
  logic             w_can_grant;
  logic             w_xfer;
  logic [CNT_W:0]   w_committed;
  logic             r_sq_start;
  logic [WIDTH-1:0] r_sq_x;
  TaggedDirection   r_sq_td;
  logic [ID_W-1:0]  r_sq_id;
  logic [CNT_W-1:0] r_inflight;
  logic             w_fifo_empty;
  logic [ID_W-1:0]  w_head_id;
  logic             w_pop;

  // Walk downward so the lowest offset after last_grant wins; offset NUM_REQ is last_grant itself.
  always_comb begin
    w_win     = r_last_grant;
    w_idx     = '0;
    w_any_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_win     = w_idx;
        w_any_vld = 1'b1;
      end
    end
  end

  // A registered-but-not-yet-counted issue still occupies a credit.
  assign w_committed = {1'b0, r_inflight} + {{CNT_W{1'b0}}, r_sq_start};
  assign w_can_grant = !reset && (r_state == ST_RUN) && (w_committed < MAX_C);
  assign w_xfer      = w_can_grant && w_any_vld;
  assign req_ready   = w_xfer ? (NUM_REQ'(1) << w_win) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_sq_start   <= 1'b0;
      r_sq_x       <= '0;
      r_sq_td      <= '0;
      r_sq_id      <= '0;
      r_inflight   <= '0;
    end else begin
      r_sq_start <= w_xfer;
      if (w_xfer) begin
        r_last_grant <= w_win;
        r_sq_x       <= req_x[w_win];
        r_sq_td      <= req_td[w_win];
        r_sq_id      <= w_win;
      end
      case ({r_sq_start, w_pop})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  sched_id_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (r_sq_start),
    .i_push_id (r_sq_id),
    .i_pop     (w_pop),
    .o_head_id (w_head_id),
    .o_empty   (w_fifo_empty)
  );

  // Stray results with nothing outstanding are dropped here.
  assign w_pop     = sq_valid && !w_fifo_empty && !reset;
  assign rsp_valid = w_pop ? (NUM_REQ'(1) << w_head_id) : '0;
  assign rsp_tdl   = w_pop ? sq_tdl : '0;

  assign sq_start  = r_sq_start && !reset;
  assign sq_x      = reset ? '0 : r_sq_x;
  assign sq_td     = reset ? '0 : r_sq_td;
  assign inflight  = r_inflight;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    flush_done  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (flush) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_inflight == '0 && !r_sq_start) begin
          w_state_nxt = ST_RUN;
          flush_done  = !reset;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

`ifdef SQRT_SCHED_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (r_sq_start && r_stat_issued != '1)
        r_stat_issued <= r_stat_issued + 32'd1;
      if ((|req_valid) && !w_xfer && r_stat_stall != '1)
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// Directed bench for sqrt_rr_scheduler: round-robin table, credit limit, in-order routing, flush and reset.
module tb_sqrt_rr_scheduler;
  import sqrt_rr_scheduler_pkg::*;

  localparam int N = 4;
  localparam int W = `WIDTH;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][W-1:0]   req_x;
  TaggedDirection [N-1:0] req_td;
  logic                  sq_start;
  logic [W-1:0]          sq_x;
  TaggedDirection        sq_td;
  logic                  sq_valid;
  TaggedDirection_len    sq_tdl;
  logic [N-1:0]          rsp_valid;
  TaggedDirection_len    rsp_tdl;
  logic                  flush;
  logic                  flush_done;
  logic [5:0]            inflight;
`ifdef SQRT_SCHED_STATS_EN
  logic [31:0]           stat_issued;
  logic [31:0]           stat_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sqrt_rr_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_td     (req_td),
    .sq_start   (sq_start),
    .sq_x       (sq_x),
    .sq_td      (sq_td),
    .sq_valid   (sq_valid),
    .sq_tdl     (sq_tdl),
    .rsp_valid  (rsp_valid),
    .rsp_tdl    (rsp_tdl),
    .flush      (flush),
    .flush_done (flush_done),
    .inflight   (inflight)
`ifdef SQRT_SCHED_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_stall (stat_stall)
`endif
  );

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  rdy;
    logic        st;
    logic [31:0] x;
  } vec_t;

  vec_t tbl[13];
  int   ord[11];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic TaggedDirection mk_td(input logic [63:0] tag, input int idx);
    TaggedDirection t;
    t       = '0;
    t.tag   = tag;
    t.dir_x = W'(idx);
    return t;
  endfunction

  // One sqrt-unit result this cycle; checks the routed response against what the bench expects.
  task automatic ret(input logic [3:0] exp_rsp, input logic [63:0] tag, input string nm);
    TaggedDirection_len t;
    TaggedDirection_len e;
    t        = '0;
    t.td.tag = tag;
    t.len    = W'(tag) ^ W'(32'h5a5a);
    e        = (exp_rsp == 4'b0) ? '0 : t;
    sq_valid = 1'b1;
    sq_tdl   = t;
    #1;
    chk({nm, "_rsp_valid"}, 256'(rsp_valid), 256'(exp_rsp));
    chk({nm, "_rsp_tdl"}, 256'(rsp_tdl), 256'(e));
    tick();
    sq_valid = 1'b0;
    sq_tdl   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;

    tbl[0]  = '{4'b1111, 4'b0001, 1'b0, 32'd0};
    tbl[1]  = '{4'b1111, 4'b0010, 1'b1, 32'd100};
    tbl[2]  = '{4'b1111, 4'b0100, 1'b1, 32'd101};
    tbl[3]  = '{4'b1111, 4'b1000, 1'b1, 32'd102};
    tbl[4]  = '{4'b1111, 4'b0001, 1'b1, 32'd103};
    tbl[5]  = '{4'b1010, 4'b0010, 1'b1, 32'd100};
    tbl[6]  = '{4'b1010, 4'b1000, 1'b1, 32'd101};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b1, 32'd103};
    tbl[8]  = '{4'b0101, 4'b0001, 1'b0, 32'd0};
    tbl[9]  = '{4'b0101, 4'b0100, 1'b1, 32'd100};
    tbl[10] = '{4'b0001, 4'b0001, 1'b1, 32'd102};
    tbl[11] = '{4'b1000, 4'b1000, 1'b1, 32'd100};
    tbl[12] = '{4'b0000, 4'b0000, 1'b1, 32'd103};
    ord = '{0, 1, 2, 3, 0, 1, 3, 0, 2, 0, 3};

    // Reset with every input active: all outputs must stay quiet.
    reset     = 1'b1;
    req_valid = '1;
    sq_valid  = 1'b1;
    sq_tdl    = '0;
    sq_tdl.len = W'(32'hdead);
    flush     = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_x[i]  = W'(100 + i);
      req_td[i] = mk_td(64'h0, i);
    end
    tick();
    tick();
    chk("rst_req_ready", 256'(req_ready), 256'(0));
    chk("rst_sq_start", 256'(sq_start), 256'(0));
    chk("rst_sq_x", 256'(sq_x), 256'(0));
    chk("rst_sq_td", 256'(sq_td), 256'(0));
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst_rsp_tdl", 256'(rsp_tdl), 256'(0));
    chk("rst_flush_done", 256'(flush_done), 256'(0));
    chk("rst_inflight", 256'(inflight), 256'(0));
    reset     = 1'b0;
    req_valid = '0;
    sq_valid  = 1'b0;
    sq_tdl    = '0;
    flush     = 1'b0;
    tick();
    chk("post_rst_flush_done", 256'(flush_done), 256'(0));

    // Round-robin table; no returns, so each grant stays in flight.
    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].vld;
      #1;
      chk($sformatf("rr_ready[%0d]", i), 256'(req_ready), 256'(tbl[i].rdy));
      chk($sformatf("rr_sq_start[%0d]", i), 256'(sq_start), 256'(tbl[i].st));
      if (tbl[i].st) chk($sformatf("rr_sq_x[%0d]", i), 256'(sq_x), 256'(tbl[i].x));
      tick();
    end
    req_valid = '0;
    chk("rr_inflight", 256'(inflight), 256'(11));
    for (int k = 0; k < 11; k++) ret(4'(1 << ord[k]), 64'(k + 1), $sformatf("rr_ret%0d", k));
    chk("rr_inflight_drained", 256'(inflight), 256'(0));

    // Credit limit: requester 2 alone until the 32-deep window is full.
    hs = 0;
    req_valid = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_ready == 4'b0100) hs++;
      tick();
    end
    chk("cr_handshakes", 256'(hs), 256'(32));
    #1;
    chk("cr_ready_full", 256'(req_ready), 256'(0));
    chk("cr_inflight_full", 256'(inflight), 256'(32));
    ret(4'b0100, 64'h200, "cr_ret");
    #1;
    chk("cr_inflight_31", 256'(inflight), 256'(31));
    chk("cr_ready_after_ret", 256'(req_ready), 256'(4'b0100));
    tick();
    req_valid = '0;
    tick();
    chk("cr_inflight_refill", 256'(inflight), 256'(32));
    for (int k = 0; k < 32; k++) ret(4'b0100, 64'(16'h2100 + k), $sformatf("cr_drain%0d", k));
    chk("cr_inflight_drained", 256'(inflight), 256'(0));

    // Interleaved 1,3,1 with a delayed sqrt unit; responses must come back in issue order.
    req_td[1] = mk_td(64'hA1, 1);
    req_valid = 4'b0010;
    #1;
    chk("il_ready0", 256'(req_ready), 256'(4'b0010));
    tick();
    req_td[3] = mk_td(64'hA3, 3);
    req_valid = 4'b1000;
    #1;
    chk("il_ready1", 256'(req_ready), 256'(4'b1000));
    chk("il_start0", 256'(sq_start), 256'(1));
    chk("il_td0", 256'(sq_td), 256'(mk_td(64'hA1, 1)));
    tick();
    req_td[1] = mk_td(64'hB1, 1);
    req_valid = 4'b0010;
    #1;
    chk("il_ready2", 256'(req_ready), 256'(4'b0010));
    chk("il_td1", 256'(sq_td), 256'(mk_td(64'hA3, 3)));
    tick();
    req_valid = '0;
    #1;
    chk("il_td2", 256'(sq_td), 256'(mk_td(64'hB1, 1)));
    tick();
    repeat (6) tick();
    ret(4'b0010, 64'hA1, "il_ret0");
    ret(4'b1000, 64'hA3, "il_ret1");
    ret(4'b0010, 64'hB1, "il_ret2");

    // Flush with five outstanding.
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("fl_issue%0d", k), 256'(req_ready), 256'(4'b0001));
      tick();
    end
    req_valid = '0;
    flush     = 1'b1;
    #1;
    chk("fl_done_at_flush", 256'(flush_done), 256'(0));
    tick();
    flush     = 1'b0;
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("fl_ready_blocked%0d", k), 256'(req_ready), 256'(0));
      chk($sformatf("fl_done_early%0d", k), 256'(flush_done), 256'(0));
      ret(4'b0001, 64'(16'h300 + k), $sformatf("fl_ret%0d", k));
    end
    #1;
    chk("fl_done_pulse", 256'(flush_done), 256'(1));
    chk("fl_ready_in_pulse", 256'(req_ready), 256'(0));
    tick();
    #1;
    chk("fl_done_cleared", 256'(flush_done), 256'(0));
    chk("fl_ready_run", 256'(req_ready), 256'(4'b0001));
    tick();
    req_valid = '0;
    tick();
    ret(4'b0001, 64'h3ff, "fl_ret_run");
    chk("fl_inflight", 256'(inflight), 256'(0));

    // Flush with nothing outstanding: pulse on the following cycle only.
    flush = 1'b1;
    #1;
    chk("fl0_done_same", 256'(flush_done), 256'(0));
    tick();
    flush = 1'b0;
    #1;
    chk("fl0_done_next", 256'(flush_done), 256'(1));
    tick();
    #1;
    chk("fl0_done_after", 256'(flush_done), 256'(0));
    tick();

    // Reset mid-operation, then stray results must be ignored.
    req_valid = 4'b0001;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk($sformatf("mr_issue%0d", k), 256'(req_ready), 256'(4'b0001));
      tick();
    end
    reset    = 1'b1;
    sq_valid = 1'b1;
    sq_tdl   = '0;
    #1;
    chk("mr_ready_in_rst", 256'(req_ready), 256'(0));
    chk("mr_start_in_rst", 256'(sq_start), 256'(0));
    chk("mr_rsp_in_rst", 256'(rsp_valid), 256'(0));
    tick();
    tick();
    chk("mr_inflight_rst", 256'(inflight), 256'(0));
    reset     = 1'b0;
    req_valid = '0;
    sq_valid  = 1'b0;
    for (int k = 0; k < 7; k++) begin
      ret(4'b0000, 64'(16'h700 + k), $sformatf("mr_stray%0d", k));
      chk($sformatf("mr_inflight%0d", k), 256'(inflight), 256'(0));
    end

`ifdef SQRT_SCHED_STATS_EN
    // 32 transfers fill the window, followed by three stalled cycles.
    req_valid = 4'b0001;
    repeat (35) tick();
    req_valid = '0;
    tick();
    chk("st_issued", 256'(stat_issued), 256'(32));
    chk("st_stall", 256'(stat_stall), 256'(3));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
